// File: rtl/phy_rf_readback.sv
// Register-readback engine: single-entry reads over req/ack, full-array
// snapshot scans into a shadow buffer, and sticky per-entry change flags.
module phy_rf_readback #(
  parameter int NUM_BANKS = 2,
  parameter int NUM_REGS  = 6,
  parameter int SCAN_GAP  = 16,
  localparam int TOTAL    = NUM_BANKS * NUM_REGS,
  localparam int ADDR_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TOTAL*8-1:0]   rf_hi_rdata,
  input  logic [TOTAL*4-1:0]   rf_mid_rdata,
  input  logic [TOTAL-1:0]     rf_b1_rdata,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_shadow,
  output logic                 rd_ack,
  output logic [15:0]          rd_data,
  output logic                 rd_err,
  input  logic                 scan_start,
  input  logic                 scan_auto,
  output logic                 scan_done,
  output logic                 busy,
  output logic [TOTAL-1:0]     chg_status,
  input  logic [TOTAL-1:0]     chg_clr,
  output logic                 chg_irq
);

  localparam int GAP_W = $clog2(SCAN_GAP + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]              state, state_nxt;
  logic                    enter_scan;
  logic [TOTAL-1:0][15:0]  live_word;
  logic [TOTAL-1:0][15:0]  shadow;
  logic                    shadow_valid;
  logic                    pending;
  logic [ADDR_W-1:0]       idx;
  logic [GAP_W-1:0]        gap_cnt;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic                    rd_sh_q;
  logic [15:0]             rd_word_q;
  logic                    rd_err_q;
  logic                    addr_ok;
  logic                    last_idx;
  logic [15:0]             rd_sel_word;
  logic [TOTAL-1:0]        chg_set;

  // Sparse field gather: only bits [15:8], [7:4] and [1] are backed.
  for (genvar i = 0; i < TOTAL; i++) begin : g_word
    assign live_word[i] = {rf_hi_rdata[i*8 +: 8], rf_mid_rdata[i*4 +: 4],
                           2'b00, rf_b1_rdata[i], 1'b0};
  end

  assign addr_ok  = {1'b0, rd_addr_q} < (ADDR_W+1)'(TOTAL);
  assign last_idx = (idx == ADDR_W'(TOTAL - 1));
  assign busy     = (state != S_IDLE);
  assign chg_irq  = |chg_status;

  always_comb begin
    rd_sel_word = 16'h0000;
    if (addr_ok)
      rd_sel_word = rd_sh_q ? shadow[rd_addr_q] : live_word[rd_addr_q];
  end

  always_comb begin
    state_nxt  = state;
    enter_scan = 1'b0;
    case (state)
      S_IDLE: begin
        // A read wins a same-cycle collision; the scan is held as pending.
        if (rd_req) begin
          state_nxt = S_RD;
        end else if (scan_start || pending) begin
          state_nxt  = S_SCAN;
          enter_scan = 1'b1;
        end
      end
      S_RD:  state_nxt = S_ACK;
      S_ACK: begin
        if (pending) begin
          state_nxt  = S_SCAN;
          enter_scan = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (last_idx) state_nxt = scan_auto ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (!scan_auto) begin
          state_nxt = S_IDLE;
        end else if (gap_cnt == GAP_W'(SCAN_GAP)) begin
          state_nxt  = S_SCAN;
          enter_scan = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      idx          <= '0;
      gap_cnt      <= '0;
      rd_addr_q    <= '0;
      rd_sh_q      <= 1'b0;
      rd_word_q    <= 16'h0000;
      rd_err_q     <= 1'b0;
      rd_ack       <= 1'b0;
      rd_data      <= 16'h0000;
      rd_err       <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_ack    <= 1'b0;
      scan_done <= 1'b0;
      // Starts arriving while busy merge into one pending request.
      pending   <= (pending | scan_start) & ~enter_scan;
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            rd_addr_q <= rd_addr;
            rd_sh_q   <= rd_shadow;
          end
        end
        S_RD: begin
          rd_word_q <= rd_sel_word;
          rd_err_q  <= ~addr_ok;
        end
        S_ACK: begin
          rd_ack  <= 1'b1;
          rd_data <= rd_word_q;
          rd_err  <= rd_err_q;
        end
        S_SCAN: begin
          shadow[idx] <= live_word[idx];
          if (last_idx) begin
            idx          <= '0;
            shadow_valid <= 1'b1;
            scan_done    <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        S_GAP: begin
          gap_cnt <= (state_nxt == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
        default: ;
      endcase
    end
  end

  // Sticky change flags; a set in the same cycle beats a clear.
  for (genvar i = 0; i < TOTAL; i++) begin : g_chg
    assign chg_set[i] = (state == S_SCAN) && (idx == ADDR_W'(i)) &&
                        shadow_valid && (live_word[i] != shadow[i]);

    always_ff @(posedge clk) begin
      if (!rst_n) chg_status[i] <= 1'b0;
      else        chg_status[i] <= chg_set[i] | (chg_status[i] & ~chg_clr[i]);
    end
  end

endmodule

// File: doc/phy_rf_readback.md
# phy_rf_readback

Parametrised register-readback engine for the PHY control subsystem. It gathers the sparse regfile read fields from NUM_BANKS register banks of NUM_REGS registers each (bank 0 = top regfile, bank 1 = PCS regfile by default). Each register exposes bits [15:8], [7:4] and [1]. The block serves single-register reads over a req/ack handshake, runs full-array snapshot scans into a shadow buffer, and flags any register whose value changed between scans.

## Interface
Parameters:
- NUM_BANKS, 2, number of register banks.
- NUM_REGS, 6, registers per bank.
- SCAN_GAP, 16, idle cycles between scans in auto mode (≥1).
- Derived: TOTAL = NUM_BANKS*NUM_REGS; ADDR_W = $clog2(TOTAL) (min 1). Entry index i = bank*NUM_REGS + reg.

Ports:
- clk  in  1  single clock for the entire block.
- rst_n  in  1  reset, synchronous, active-low.
- rf_hi_rdata  in  TOTAL*8  field [15:8] of entry i at [i*8+:8].
- rf_mid_rdata  in  TOTAL*4  field [7:4] of entry i at [i*4+:4].
- rf_b1_rdata  in  TOTAL  bit [1] of entry i at [i].
- rd_req  in  1  single-cycle read request pulse.
- rd_addr  in  ADDR_W  entry index, sampled with rd_req.
- rd_shadow  in  1  sampled with rd_req; 1 = return the shadow copy, 0 = return the live value.
- rd_ack  out  1  one-cycle pulse; rd_data and rd_err are valid in this cycle.
- rd_data  out  16  assembled word; held until the next rd_ack.
- rd_err  out  1  rd_addr ≥ TOTAL; held with rd_data.
- scan_start  in  1  request one full scan.
- scan_auto  in  1  level; 1 = rescan continuously.
- scan_done  out  1  one-cycle pulse at the end of each scan.
- busy  out  1  FSM not in IDLE.
- chg_status  out  TOTAL  sticky per-entry change flags.
- chg_clr  in  TOTAL  write-1-to-clear for chg_status.
- chg_irq  out  1  OR-reduction of chg_status.

## Operation
- Word assembly: {hi[7:0], mid[3:0], 2'b00, b1, 1'b0}. All other bits are always 0.
- FSM states: IDLE, RD, ACK, SCAN, GAP.
- IDLE→RD: on rd_req. Latch the request, then sample the selected live or shadow word into rd_data in RD.
- RD→ACK: rd_ack=1 in the ACK cycle, then return to IDLE.
- Out-of-range address: rd_data=0 and rd_err=1. No other side effects.
- IDLE→SCAN: on scan_start, or on a pending start. Index counter starts at 0 and advances one entry per cycle.
- Per entry i in SCAN:
  - If shadow_valid and live ≠ shadow[i], set chg_status[i].
  - Write shadow[i] = live.
- After index TOTAL-1:
  - Set shadow_valid=1 and pulse scan_done.
  - Then go to GAP if scan_auto=1, else IDLE.
- GAP counts SCAN_GAP cycles, then goes to SCAN. If scan_auto drops during GAP, go to IDLE at the next edge.
- rd_req and scan_start arriving together in IDLE: the read wins; the scan is latched as pending (one-deep) and starts after ACK.
- scan_start while busy: latched as pending; further starts merge into it. The pending flag clears when the scan begins.
- rd_req while busy: ignored, no ack. Requesters must check busy.
- chg_status: set has priority over chg_clr in the same cycle for the same bit. chg_irq is combinational from the chg_status register.
- First scan after reset (shadow_valid=0) never sets chg_status.

## Timing
- Reset values:
  - Outputs: rd_ack=0, rd_data=0, rd_err=0, scan_done=0, busy=0, chg_status=0, chg_irq=0.
  - Internal: shadow all 0, shadow_valid=0, pending=0, index and gap counters 0, FSM=IDLE.
- Read: rd_req sampled at edge k → RD at k+1 → rd_ack high in the cycle after edge k+2 (2-cycle latency). The next read is accepted at edge k+3 at the earliest.
- Scan: scan_start sampled at edge k → entries 0..TOTAL-1 are processed at edges k+1..k+TOTAL. scan_done is high in the cycle after edge k+TOTAL, and busy is high from k+1 through that cycle.
- Auto-mode period = TOTAL + SCAN_GAP + 1 cycles, from scan start to next scan start.
- Reset mid-operation: everything returns to reset values at the next edge. The in-flight read produces no ack; a partial scan is discarded and shadow_valid=0.
- Inputs are synchronous to clk. rf_* fields must be stable in the cycle they are sampled.

## Test plan
- Reset, then rd_req addr=7 with hi=0xA5, mid=0x3, b1=1 → rd_ack two cycles later, rd_data=0xA532, rd_err=0.
- rd_req addr=12 (TOTAL=12) → rd_data=0x0000, rd_err=1.
- First scan_start → scan_done 12 cycles after the start edge, chg_status=0. Change entry 4 and scan again → chg_status=0x010, chg_irq=1. Assert chg_clr=0x010 → chg_irq=0.
- rd_req and scan_start in the same cycle → read acked first, scan begins the cycle after ACK, scan_done follows 12 cycles later.
- scan_auto=1, SCAN_GAP=16 → scan_done pulses every 29 cycles. Drop scan_auto during GAP → IDLE, busy=0.
- rst_n=0 at scan index 5 → next cycle busy=0, shadow_valid=0, chg_status=0. The following scan sets no flags.
